// File: rtl/char_string_sequencer_pkg.sv
// Shared types and constants for the character-string sequencer and its buffer.
package seq_pkg;

   localparam int MAX_CHARS_D  = 16;
   localparam int CHAR_PITCH_D = 24;
   localparam int PIX_PER_CHAR = 25;
   localparam int CNT_W        = $clog2(MAX_CHARS_D) + 1;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      SETUP  = 3'd2,
      DRAW   = 3'd3,
      NEXT   = 3'd4,
      FINISH = 3'd5
   } state_e;

   // PS/2 set-2 codes for function keys, for hosts that map them to commands
   localparam logic [7:0] SC_F1 = 8'h05;
   localparam logic [7:0] SC_F2 = 8'h06;
   localparam logic [7:0] SC_F3 = 8'h04;

endpackage

// File: rtl/char_string_sequencer_if.sv
// Host-side buffer/control signals plus the datapath control bundle for the sequencer.
interface char_string_sequencer_if;
   import seq_pkg::*;

   logic             wr_en;
   logic [7:0]       wr_data;
   logic             clear;
   logic             start;
   logic [8:0]       base_x;
   logic [8:0]       base_y;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] count;
   logic             full;
   logic [7:0]       address;
   logic             ld_value;
   logic             ld_colour;
   logic             next_colour;
   logic             reset_counter;
   logic             enable_counter;
   logic [8:0]       x_input;
   logic [8:0]       y_input;
   logic             plot;

   modport master (
      output wr_en, wr_data, clear, start, base_x, base_y,
      input  busy, done, count, full, address, ld_value, ld_colour, next_colour,
             reset_counter, enable_counter, x_input, y_input, plot
   );

   modport slave (
      input  wr_en, wr_data, clear, start, base_x, base_y,
      output busy, done, count, full, address, ld_value, ld_colour, next_colour,
             reset_counter, enable_counter, x_input, y_input, plot
   );

endinterface

// File: rtl/char_string_sequencer_buffer.sv
// Scan-code register file with fill count; writes and clears only take effect when idle.
module char_buffer #(
   parameter int DEPTH = 16,
   parameter int IW    = $clog2(DEPTH),
   parameter int CW    = IW + 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_wr_en,
   input  logic [7:0]    i_wr_data,
   input  logic          i_clear,
   input  logic          i_idle,
   input  logic [IW-1:0] i_rd_idx,
   output logic [7:0]    o_rd_data,
   output logic [CW-1:0] o_count,
   output logic          o_full
);

   logic [7:0]    r_mem [DEPTH];
   logic [CW-1:0] r_count;
   logic          w_full;
   logic          w_wr;
   logic          w_clr;

   assign w_full = (r_count == CW'(DEPTH));
   assign w_clr  = i_idle & i_clear;
   assign w_wr   = i_idle & i_wr_en & ~i_clear & ~w_full;

   // Contents are don't-care after reset, so the array carries no reset
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_count[IW-1:0]] <= i_wr_data;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     r_count <= '0;
      else if (w_clr) r_count <= '0;
      else if (w_wr)  r_count <= r_count + CW'(1);
   end

   assign o_rd_data = r_mem[i_rd_idx];
   assign o_count   = r_count;
   assign o_full    = w_full;

endmodule

// File: rtl/char_string_sequencer.sv
// Walks the scan-code buffer and sequences the 5x5 character datapath, one char per 28 cycles.
module char_string_sequencer
   import seq_pkg::*;
#(
   parameter int MAX_CHARS  = MAX_CHARS_D,
   parameter int CHAR_PITCH = CHAR_PITCH_D
) (
   input  logic                    clk,
   input  logic                    rst_n,
   char_string_sequencer_if.slave  bus
);

   localparam int IW = $clog2(MAX_CHARS);

   state_e        r_state;
   logic [IW-1:0] r_idx;
   logic [4:0]    r_pix;
   logic [7:0]    r_addr;
   logic [8:0]    r_x;
   logic [8:0]    r_y;
   logic          r_plot;

   logic          w_idle;
   logic          w_last;
   logic [IW-1:0] w_rd_idx;
   logic [7:0]    w_rd_data;
   logic [CNT_W-1:0] w_count;
   logic          w_full;

   assign w_idle = (r_state == IDLE);

   // Read port looks one character ahead so address is registered on entry to LOAD
   assign w_rd_idx = w_idle ? '0 : r_idx + IW'(1);
   assign w_last   = (CNT_W'(r_idx) == w_count - CNT_W'(1));

   char_buffer #(.DEPTH(MAX_CHARS)) u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (bus.wr_en),
      .i_wr_data (bus.wr_data),
      .i_clear   (bus.clear),
      .i_idle    (w_idle),
      .i_rd_idx  (w_rd_idx),
      .o_rd_data (w_rd_data),
      .o_count   (w_count),
      .o_full    (w_full)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_pix   <= '0;
         r_addr  <= '0;
         r_x     <= '0;
         r_y     <= '0;
         r_plot  <= 1'b0;
      end else begin
         r_plot <= (r_state == DRAW);
         unique case (r_state)
            IDLE: begin
               if (bus.start) begin
                  if (w_count == '0) begin
                     r_state <= FINISH;
                  end else begin
                     r_state <= LOAD;
                     r_idx   <= '0;
                     r_addr  <= w_rd_data;
                     r_x     <= bus.base_x;
                     r_y     <= bus.base_y;
                  end
               end
            end
            LOAD:  r_state <= SETUP;
            SETUP: begin
               r_pix   <= '0;
               r_state <= DRAW;
            end
            DRAW: begin
               r_pix <= r_pix + 5'd1;
               if (r_pix == 5'(PIX_PER_CHAR - 1)) r_state <= NEXT;
            end
            NEXT: begin
               r_idx <= r_idx + IW'(1);
               if (w_last) begin
                  r_state <= FINISH;
               end else begin
                  r_state <= LOAD;
                  r_addr  <= w_rd_data;
                  r_x     <= r_x + 9'(CHAR_PITCH);
               end
            end
            FINISH:  r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.busy           = ~w_idle;
   assign bus.done           = (r_state == FINISH);
   assign bus.count          = w_count;
   assign bus.full           = w_full;
   assign bus.address        = r_addr;
   assign bus.reset_counter  = (r_state == LOAD);
   assign bus.ld_value       = (r_state == SETUP);
   assign bus.ld_colour      = (r_state == SETUP);
   assign bus.next_colour    = (r_state == DRAW);
   assign bus.enable_counter = (r_state == DRAW);
   assign bus.x_input        = r_x;
   assign bus.y_input        = r_y;
   assign bus.plot           = r_plot;

endmodule

// File: tb/tb_char_string_sequencer.sv
// Randomized bench: per-cycle control/address/coordinate timeline derived from a queue model.
module tb_char_string_sequencer;
   import seq_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   char_string_sequencer_if ifc ();

   char_string_sequencer dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int         n_chk  = 0;
   int         n_fail = 0;
   logic [7:0] q[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] ctl_now();
      return {ifc.busy, ifc.done, ifc.reset_counter, ifc.ld_value, ifc.ld_colour,
              ifc.next_colour, ifc.enable_counter, ifc.plot};
   endfunction

   task automatic wr(input logic [7:0] d, input logic clr);
      ifc.wr_en   = 1'b1;
      ifc.wr_data = d;
      ifc.clear   = clr;
      @(negedge clk);
      ifc.wr_en = 1'b0;
      ifc.clear = 1'b0;
      if (clr) q.delete();
      else if (q.size() < 16) q.push_back(d);
      chk("count", 32'(ifc.count), 32'(q.size()));
      chk("full", 32'(ifc.full), 32'(q.size() == 16));
   endtask

   // Each char: offset 0 LOAD, 1 SETUP, 2..26 DRAW, 27 NEXT; then one FINISH cycle.
   task automatic run_draw(input logic [8:0] bx, input logic [8:0] by, input bit noise);
      int n;
      int cyc;
      int plots;
      int dones;
      int k;
      int o;
      logic [7:0] exp_ctl;
      n     = q.size();
      cyc   = 28 * n + 1;
      plots = 0;
      dones = 0;
      ifc.base_x = bx;
      ifc.base_y = by;
      ifc.start  = 1'b1;
      @(negedge clk);
      ifc.start  = 1'b0;
      ifc.base_x = 9'($urandom);
      ifc.base_y = 9'($urandom);
      for (int c = 0; c < cyc; c++) begin
         if (c == cyc - 1) begin
            exp_ctl = 8'b1100_0000;
         end else begin
            k = c / 28;
            o = c % 28;
            exp_ctl = {1'b1, 1'b0, (o == 0), (o == 1), (o == 1),
                       (o >= 2 && o <= 26), (o >= 2 && o <= 26), (o >= 3)};
            chk("address", 32'(ifc.address), 32'(q[k]));
            chk("x_input", 32'(ifc.x_input), 32'((int'(bx) + 24 * k) % 512));
            chk("y_input", 32'(ifc.y_input), 32'(by));
         end
         chk("ctl", 32'(ctl_now()), 32'(exp_ctl));
         plots += int'(ifc.plot);
         dones += int'(ifc.done);
         if (noise) begin
            ifc.wr_en   = 1'($urandom_range(0, 1));
            ifc.wr_data = 8'($urandom);
            ifc.clear   = 1'($urandom_range(0, 1));
            ifc.start   = 1'($urandom_range(0, 1));
         end
         @(negedge clk);
      end
      ifc.wr_en = 1'b0;
      ifc.clear = 1'b0;
      ifc.start = 1'b0;
      chk("plot_total", 32'(plots), 32'(25 * n));
      chk("done_total", 32'(dones), 32'd1);
      chk("ctl_after", 32'(ctl_now()), 32'd0);
      chk("count_after", 32'(ifc.count), 32'(q.size()));
   endtask

   initial begin
      int dones;
      ifc.wr_en   = 1'b0;
      ifc.wr_data = '0;
      ifc.clear   = 1'b0;
      ifc.start   = 1'b0;
      ifc.base_x  = '0;
      ifc.base_y  = '0;
      repeat (2) @(negedge clk);
      chk("rst_ctl", 32'(ctl_now()), 32'd0);
      chk("rst_count", 32'(ifc.count), 32'd0);
      chk("rst_full", 32'(ifc.full), 32'd0);
      chk("rst_addr", 32'(ifc.address), 32'd0);
      chk("rst_xy", 32'({ifc.x_input, ifc.y_input}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);

      // Two characters at (10,20)
      wr(8'h1C, 1'b0);
      wr(8'h32, 1'b0);
      run_draw(9'd10, 9'd20, 1'b0);

      // Empty buffer: FINISH straight after start
      wr(8'h00, 1'b1);
      run_draw(9'd3, 9'd4, 1'b0);

      // Overfill then clear-with-write
      for (int i = 0; i < 17; i++) wr(8'($urandom), 1'b0);
      wr(8'hAA, 1'b1);

      // x wrap at the 9-bit boundary
      wr(SC_F1, 1'b0);
      wr(SC_F2, 1'b0);
      run_draw(9'd500, 9'd7, 1'b0);

      // Full buffer draw with interference while busy
      for (int i = 0; i < 16; i++) wr(8'($urandom), 1'b0);
      run_draw(9'($urandom), 9'($urandom), 1'b1);

      // Abort mid-draw via reset
      wr(8'h00, 1'b1);
      wr(8'h1C, 1'b0);
      wr(8'h1D, 1'b0);
      ifc.start = 1'b1;
      @(negedge clk);
      ifc.start = 1'b0;
      repeat (6) @(negedge clk);
      chk("pre_abort_draw", 32'(ifc.enable_counter), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_ctl", 32'(ctl_now()), 32'd0);
      chk("abort_count", 32'(ifc.count), 32'd0);
      chk("abort_xy", 32'({ifc.address, ifc.x_input, ifc.y_input}), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      q.delete();
      dones = 0;
      for (int i = 0; i < 60; i++) begin
         dones += int'(ifc.done) + int'(ifc.busy);
         @(negedge clk);
      end
      chk("abort_quiet", 32'(dones), 32'd0);

      // Random rounds
      for (int r = 0; r < 10; r++) begin
         if ($urandom_range(0, 2) == 0) wr(8'h00, 1'b1);
         for (int i = 0; i < int'($urandom_range(0, 6)); i++) wr(8'($urandom), 1'b0);
         run_draw(9'($urandom), 9'($urandom), 1'($urandom_range(0, 1)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
